buffer_reader: RTL and testbench
================================

Name: buffer_reader

Overview:
- Read-side consumer for the clk_2 domain of the dual-clock word buffer.
- Pops one 16-bit word at a time from the buffer's read interface and presents it to the display manager.
- Holds each word stable for a programmable number of cycles, then pops the next.
- Generates per-word parity, a 6-bit consumed-word counter for the LEDs, and a drain handshake so the top-level FSM can leave its buffer-empty state cleanly.

Parameters:
- HOLD_CYCLES, 4, cycles each word stays on data_out before the next pop; minimum 1.
- TIMEOUT, 8, cycles to wait for rd_valid after rd_en before aborting the read.
- CNT_W, 6, width of word_count.

Ports:
- clk  in  1  block clock (clk_2 domain).
- rst  in  1  reset.
- en  in  1  consumption enable; level.
- drain  in  1  level; bypass the hold period and empty the buffer.
- buf_empty  in  1  buffer has no words to read.
- rd_valid  in  1  one-cycle strobe; rd_data is valid.
- rd_data  in  16  word from the buffer.
- rd_en  out  1  one-cycle pop request to the buffer.
- data_out  out  16  last word consumed, held stable.
- data_out_valid  out  1  one-cycle pulse when data_out updates.
- parity  out  1  XOR of all data_out bits; 1 = odd number of ones.
- word_count  out  CNT_W  words consumed since reset.
- drain_done  out  1  one-cycle pulse: drain requested, buffer empty, reader idle.
- rd_err  out  1  sticky read-timeout flag.

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Outputs on reset:
  - rd_en, data_out_valid, drain_done, rd_err = 0.
  - data_out = 16'h0000, parity = 0, word_count = 0.
  - FSM goes to IDLE; hold and timeout counters clear.
- Reset mid-operation applies all of the above on the next edge. Any word in flight is discarded and not counted.
- All outputs are registered.
- FSM states are IDLE, REQ, WAIT, HOLD.
- IDLE:
  - If (en | drain) & !buf_empty, go to REQ.
  - Else, if drain & buf_empty, pulse drain_done for 1 cycle, then stay in IDLE while drain remains high; the pulse fires once per drain assertion (edge-armed).
  - Else, stay in IDLE.
- REQ:
  - rd_en = 1 for exactly this cycle.
  - Go to WAIT; the timeout counter clears.
- WAIT:
  - On rd_valid:
    - data_out <= rd_data; parity <= ^rd_data; data_out_valid pulses the next cycle.
    - word_count increments, wrapping from 2^CNT_W-1 to 0.
    - Go to HOLD with hold counter = 0.
  - If no rd_valid by the time the counter reaches TIMEOUT-1:
    - rd_err <= 1 (sticky until rst); go to IDLE.
    - data_out, parity and word_count are unchanged.
  - rd_valid in any state other than WAIT is ignored and not counted.
- HOLD:
  - The counter increments each cycle.
  - When it reaches HOLD_CYCLES-1, or immediately if drain = 1, go to IDLE.
  - en dropping during HOLD does not truncate the hold; it only blocks the next pop.
- Latency:
  - IDLE-with-data to rd_en high is 1 cycle.
  - rd_valid to data_out update is 1 cycle.
  - Pop period in steady state (buffer never empty, drain = 0, rd_valid 1 cycle after rd_en) is HOLD_CYCLES + 3 cycles.
- At most one outstanding pop; rd_en never asserts while in WAIT or HOLD.
- buf_empty is sampled only in IDLE. If buf_empty rises between IDLE and REQ, the pop still issues, and the WAIT timeout covers a missing response.
- en and drain both high: drain wins (no hold).

Test Plan:
- Reset: apply rst for 2 cycles with en = 1, buf_empty = 0 → all outputs 0, and no rd_en within 2 cycles after release other than the first pop at cycle 2.
- Single word: en = 1, one word 16'hA5A5, rd_valid 1 cycle after rd_en → data_out = A5A5, parity = 0, word_count = 1, data_out_valid high for exactly 1 cycle; the next rd_en does not occur for at least HOLD_CYCLES + 1 cycles.
- Stream and wrap: preload 70 words 16'h0001 with buffer model latency 1, HOLD_CYCLES = 4 → rd_en period is exactly 7 cycles; parity = 1 on each word; word_count reads 6 after 70 pops (wrap at 64).
- Drain: 5 words queued, en = 0, drain = 1 → 5 pops spaced 3 cycles apart (no hold); drain_done pulses once after buf_empty; holding drain high produces no second pulse.
- Timeout: rd_en issued, buffer model withholds rd_valid → rd_err = 1 after TIMEOUT = 8 cycles, FSM returns to IDLE, word_count unchanged; a later valid pop succeeds with rd_err still 1.
- Stray strobe and mid-op reset: rd_valid pulsed in IDLE → word_count unchanged; rst asserted during HOLD → data_out = 0, word_count = 0 next cycle.

Source files
------------

// File: rtl/buffer_reader_if.sv
// Signal bundle between the clk_2 word-buffer read port, the buffer reader and the display side.
// The master modport is the reader; the slave modport is its environment.
interface buffer_reader_if #(
    parameter int CNT_W = 6
);
    logic             en;
    logic             drain;
    logic             buf_empty;
    logic             rd_valid;
    logic [15:0]      rd_data;
    logic             rd_en;
    logic [15:0]      data_out;
    logic             data_out_valid;
    logic             parity;
    logic [CNT_W-1:0] word_count;
    logic             drain_done;
    logic             rd_err;

    modport master (
        input  en, drain, buf_empty, rd_valid, rd_data,
        output rd_en, data_out, data_out_valid, parity, word_count, drain_done, rd_err
    );

    modport slave (
        output en, drain, buf_empty, rd_valid, rd_data,
        input  rd_en, data_out, data_out_valid, parity, word_count, drain_done, rd_err
    );
endinterface

// File: rtl/buffer_reader.sv
// Read-side consumer of the dual-clock word buffer: pops one word, holds it for the
// display, tracks parity, a consumed-word count, drain completion and read timeouts.
module buffer_reader #(
    parameter int HOLD_CYCLES = 4,
    parameter int TIMEOUT     = 8,
    parameter int CNT_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    buffer_reader_if.master   bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    function automatic logic word_parity(input logic [15:0] word);
        return ^word;
    endfunction

    logic [1:0]        state_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [TO_W-1:0]   tmo_cnt_r;
    logic              rd_en_r;
    logic [15:0]       data_r;
    logic              data_valid_r;
    logic              parity_r;
    logic [CNT_W-1:0]  count_r;
    logic              drain_done_r;
    logic              drain_armed_r;
    logic              rd_err_r;

    // Reader FSM together with every registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            hold_cnt_r    <= {HOLD_W{1'b0}};
            tmo_cnt_r     <= {TO_W{1'b0}};
            rd_en_r       <= 1'b0;
            data_r        <= 16'h0000;
            data_valid_r  <= 1'b0;
            parity_r      <= 1'b0;
            count_r       <= {CNT_W{1'b0}};
            drain_done_r  <= 1'b0;
            drain_armed_r <= 1'b1;
            rd_err_r      <= 1'b0;
        end else begin
            rd_en_r      <= 1'b0;
            data_valid_r <= 1'b0;
            drain_done_r <= 1'b0;
            // Dropping drain re-arms the one-shot completion pulse.
            if (!bus.drain) begin
                drain_armed_r <= 1'b1;
            end else begin
                drain_armed_r <= drain_armed_r;
            end
            case (state_r)
                IDLE: begin
                    if ((bus.en || bus.drain) && !bus.buf_empty) begin
                        state_r <= REQ;
                        rd_en_r <= 1'b1;
                    end else if (bus.drain && bus.buf_empty && drain_armed_r) begin
                        drain_done_r  <= 1'b1;
                        drain_armed_r <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    state_r   <= WAIT;
                    tmo_cnt_r <= {TO_W{1'b0}};
                end
                WAIT: begin
                    if (bus.rd_valid) begin
                        data_r       <= bus.rd_data;
                        parity_r     <= word_parity(bus.rd_data);
                        data_valid_r <= 1'b1;
                        count_r      <= count_r + CNT_W'(1);
                        hold_cnt_r   <= {HOLD_W{1'b0}};
                        // While draining the hold period is skipped entirely.
                        state_r      <= bus.drain ? IDLE : HOLD;
                    end else if (tmo_cnt_r == TO_LAST) begin
                        rd_err_r <= 1'b1;
                        state_r  <= IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TO_W'(1);
                    end
                end
                HOLD: begin
                    if (bus.drain || (hold_cnt_r == HOLD_LAST)) begin
                        state_r <= IDLE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.rd_en          = rd_en_r;
    assign bus.data_out       = data_r;
    assign bus.data_out_valid = data_valid_r;
    assign bus.parity         = parity_r;
    assign bus.word_count     = count_r;
    assign bus.drain_done     = drain_done_r;
    assign bus.rd_err         = rd_err_r;
endmodule

// File: tb/tb_buffer_reader.sv
// Directed bench for buffer_reader with a small word-buffer model answering pops one cycle later.
module tb_buffer_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    buffer_reader_if #(.CNT_W(6)) bus ();

    buffer_reader #(.HOLD_CYCLES(4), .TIMEOUT(8), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Buffer model: word queue, response one cycle after rd_en unless withheld.
    logic [15:0] bq[$];
    logic        withhold   = 1'b0;
    logic        stray      = 1'b0;
    logic        pend       = 1'b0;
    logic [15:0] pend_data  = 16'h0000;
    logic        m_valid    = 1'b0;
    logic [15:0] m_data     = 16'h0000;
    logic        m_empty    = 1'b1;

    assign bus.rd_valid  = m_valid;
    assign bus.rd_data   = m_data;
    assign bus.buf_empty = m_empty;

    always @(posedge clk) begin
        #1;
        m_valid = 1'b0;
        if (pend) begin
            m_valid = 1'b1;
            m_data  = pend_data;
            pend    = 1'b0;
        end else if (stray) begin
            m_valid = 1'b1;
            m_data  = 16'hDEAD;
            stray   = 1'b0;
        end
        if (bus.rd_en && !withhold && bq.size() > 0) begin
            pend      = 1'b1;
            pend_data = bq.pop_front();
        end
        m_empty = (bq.size() == 0);
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1; bus.en = 1'b0; bus.drain = 1'b0; withhold = 1'b0; stray = 1'b0;
        bq.delete();
        tick; tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        int extra;
        bq.delete(); bq.push_back(16'h1111);
        withhold = 1'b0; bus.drain = 1'b0; bus.en = 1'b1; rst = 1'b1;
        tick; tick;
        n_cmp++; if (bus.rd_en !== 1'b0) begin n_bad++; $display("FAIL rst_rd_en got %b want 0", bus.rd_en); end
        n_cmp++; if (bus.data_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_dov got %b want 0", bus.data_out_valid); end
        n_cmp++; if (bus.drain_done !== 1'b0) begin n_bad++; $display("FAIL rst_drain_done got %b want 0", bus.drain_done); end
        n_cmp++; if (bus.rd_err !== 1'b0) begin n_bad++; $display("FAIL rst_rd_err got %b want 0", bus.rd_err); end
        n_cmp++; if (bus.data_out !== 16'h0000) begin n_bad++; $display("FAIL rst_data_out got %h want 0000", bus.data_out); end
        n_cmp++; if (bus.parity !== 1'b0) begin n_bad++; $display("FAIL rst_parity got %b want 0", bus.parity); end
        n_cmp++; if (bus.word_count !== 6'd0) begin n_bad++; $display("FAIL rst_word_count got %0d want 0", bus.word_count); end
        rst = 1'b0;
        tick;
        n_cmp++; if (bus.rd_en !== 1'b1) begin n_bad++; $display("FAIL rst_first_pop got %b want 1", bus.rd_en); end
        extra = 0;
        for (int i = 0; i < 2; i++) begin tick; if (bus.rd_en) extra++; end
        n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL rst_extra_pops got %0d want 0", extra); end
        bus.en = 1'b0;
        repeat (8) tick;
    endtask

    task automatic test_single;
        int t0, t1, ndov, wide;
        logic prev;
        do_reset;
        bq.push_back(16'hA5A5); bq.push_back(16'h0007);
        tick;
        bus.en = 1'b1;
        t0 = -1; t1 = -1; ndov = 0; wide = 0; prev = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (bus.rd_en) begin if (t0 < 0) t0 = i; else if (t1 < 0) t1 = i; end
            if (bus.data_out_valid) begin
                ndov++;
                if (prev) wide++;
                if (ndov == 1) begin
                    n_cmp++; if (bus.data_out !== 16'hA5A5) begin n_bad++; $display("FAIL single_data got %h want a5a5", bus.data_out); end
                    n_cmp++; if (bus.parity !== 1'b0) begin n_bad++; $display("FAIL single_parity got %b want 0", bus.parity); end
                    n_cmp++; if (bus.word_count !== 6'd1) begin n_bad++; $display("FAIL single_count got %0d want 1", bus.word_count); end
                end
            end
            prev = bus.data_out_valid;
        end
        n_cmp++; if (t0 < 0 || t1 - t0 !== 7) begin n_bad++; $display("FAIL single_pop_gap got %0d want 7", t1 - t0); end
        n_cmp++; if (ndov !== 2 || wide !== 0) begin n_bad++; $display("FAIL single_dov_pulses got %0d (wide %0d) want 2 (wide 0)", ndov, wide); end
        n_cmp++; if (bus.data_out !== 16'h0007 || bus.parity !== 1'b1) begin n_bad++; $display("FAIL single_second got %h/%b want 0007/1", bus.data_out, bus.parity); end
        bus.en = 1'b0;
    endtask

    task automatic test_stream;
        int last, pops, ndov, bad_per, bad_par;
        do_reset;
        for (int k = 0; k < 70; k++) bq.push_back(16'h0001);
        tick;
        bus.en = 1'b1;
        last = -1; pops = 0; ndov = 0; bad_per = 0; bad_par = 0;
        for (int i = 0; i < 520; i++) begin
            tick;
            if (bus.rd_en) begin
                if (last >= 0 && i - last != 7) bad_per++;
                last = i; pops++;
            end
            if (bus.data_out_valid) begin
                ndov++;
                if (bus.parity !== 1'b1) bad_par++;
            end
        end
        n_cmp++; if (pops !== 70 || ndov !== 70) begin n_bad++; $display("FAIL stream_pops got %0d/%0d want 70/70", pops, ndov); end
        n_cmp++; if (bad_per !== 0) begin n_bad++; $display("FAIL stream_period got %0d bad gaps want 0", bad_per); end
        n_cmp++; if (bad_par !== 0) begin n_bad++; $display("FAIL stream_parity got %0d bad want 0", bad_par); end
        n_cmp++; if (bus.word_count !== 6'd6) begin n_bad++; $display("FAIL stream_wrap got %0d want 6", bus.word_count); end
        bus.en = 1'b0;
    endtask

    task automatic test_drain;
        int last, pops, bad_sp, dd, idle_pops;
        do_reset;
        for (int k = 0; k < 5; k++) bq.push_back(16'h0010 + 16'(k));
        idle_pops = 0;
        for (int i = 0; i < 3; i++) begin tick; if (bus.rd_en) idle_pops++; end
        n_cmp++; if (idle_pops !== 0) begin n_bad++; $display("FAIL drain_disabled_pops got %0d want 0", idle_pops); end
        bus.drain = 1'b1;
        last = -1; pops = 0; bad_sp = 0; dd = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (bus.rd_en) begin
                if (last >= 0 && i - last != 3) bad_sp++;
                last = i; pops++;
            end
            if (bus.drain_done) dd++;
        end
        n_cmp++; if (pops !== 5 || bad_sp !== 0) begin n_bad++; $display("FAIL drain_pops got %0d (bad gaps %0d) want 5 (0)", pops, bad_sp); end
        n_cmp++; if (dd !== 1) begin n_bad++; $display("FAIL drain_done_once got %0d want 1", dd); end
        n_cmp++; if (bus.word_count !== 6'd5 || bus.data_out !== 16'h0014) begin n_bad++; $display("FAIL drain_result got %0d/%h want 5/0014", bus.word_count, bus.data_out); end
        bus.drain = 1'b0;
        tick;
        bus.drain = 1'b1;
        dd = 0;
        for (int i = 0; i < 5; i++) begin tick; if (bus.drain_done) dd++; end
        n_cmp++; if (dd !== 1) begin n_bad++; $display("FAIL drain_rearm got %0d want 1", dd); end
        bus.drain = 1'b0;
        // en and drain together: drain wins, no hold between pops
        do_reset;
        bq.push_back(16'h0101); bq.push_back(16'h0202);
        bus.en = 1'b1; bus.drain = 1'b1;
        last = -1; pops = 0; bad_sp = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (bus.rd_en) begin
                if (last >= 0 && i - last != 3) bad_sp++;
                last = i; pops++;
            end
        end
        n_cmp++; if (pops !== 2 || bad_sp !== 0) begin n_bad++; $display("FAIL drain_priority got %0d pops (bad gaps %0d) want 2 (0)", pops, bad_sp); end
        bus.en = 1'b0; bus.drain = 1'b0;
    endtask

    task automatic test_timeout;
        int t0, te, pops;
        bit seen;
        do_reset;
        withhold = 1'b1;
        bq.push_back(16'hBEEF);
        tick;
        bus.en = 1'b1;
        t0 = -1; te = -1; pops = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (bus.rd_en) begin pops++; if (t0 < 0) t0 = i; end
            if (bus.rd_err && te < 0) begin te = i; bus.en = 1'b0; end
        end
        n_cmp++; if (t0 < 0 || te - t0 !== 9) begin n_bad++; $display("FAIL timeout_latency got %0d want 9", te - t0); end
        n_cmp++; if (pops !== 1) begin n_bad++; $display("FAIL timeout_pops got %0d want 1", pops); end
        n_cmp++; if (bus.word_count !== 6'd0 || bus.data_out !== 16'h0000) begin n_bad++; $display("FAIL timeout_unchanged got %0d/%h want 0/0000", bus.word_count, bus.data_out); end
        withhold = 1'b0;
        bus.en = 1'b1;
        tick;
        n_cmp++; if (bus.rd_en !== 1'b1) begin n_bad++; $display("FAIL timeout_back_to_idle got %b want 1", bus.rd_en); end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin tick; if (bus.data_out_valid) seen = 1'b1; end
        n_cmp++; if (!seen || bus.data_out !== 16'hBEEF || bus.word_count !== 6'd1) begin n_bad++; $display("FAIL timeout_retry got %h/%0d want beef/1", bus.data_out, bus.word_count); end
        n_cmp++; if (bus.rd_err !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky got %b want 1", bus.rd_err); end
        bus.en = 1'b0;
    endtask

    task automatic test_stray_reset;
        int ndov;
        bit seen;
        do_reset;
        stray = 1'b1;
        ndov = 0;
        for (int i = 0; i < 4; i++) begin tick; if (bus.data_out_valid) ndov++; end
        n_cmp++; if (bus.word_count !== 6'd0 || ndov !== 0) begin n_bad++; $display("FAIL stray_ignored got %0d/%0d want 0/0", bus.word_count, ndov); end
        bq.push_back(16'h1234);
        bus.en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin tick; if (bus.data_out_valid) seen = 1'b1; end
        n_cmp++; if (!seen || bus.data_out !== 16'h1234 || bus.parity !== 1'b1) begin n_bad++; $display("FAIL midop_word got %h/%b want 1234/1", bus.data_out, bus.parity); end
        tick;
        rst = 1'b1;
        tick;
        n_cmp++; if (bus.data_out !== 16'h0000 || bus.word_count !== 6'd0 || bus.parity !== 1'b0) begin n_bad++; $display("FAIL midop_reset got %h/%0d/%b want 0000/0/0", bus.data_out, bus.word_count, bus.parity); end
        rst = 1'b0;
        bus.en = 1'b0;
        tick;
    endtask

    initial begin
        bus.en = 1'b0;
        bus.drain = 1'b0;
        test_reset;
        test_single;
        test_stream;
        test_drain;
        test_timeout;
        test_stray_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
